// File: rtl/piece_ctrl_pkg.sv
// Shared types and board geometry for the falling-piece controller.
package piece_ctrl_pkg;

  localparam int unsigned BOARD_W = 12;
  localparam int unsigned BOARD_H = 12;
  localparam int unsigned CELLS   = BOARD_W * BOARD_H;
  localparam int unsigned CTR_W   = 10;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned LINES_W = 8;

  typedef logic [CELLS-1:0] board_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_READY,
    ST_ROT_WAIT,
    ST_ROT_SAMPLE,
    ST_LOCK,
    ST_CLEAR,
    ST_OVER
  } state_t;

  // New-piece payload as presented by the piece generator.
  typedef struct packed {
    board_t           sqs;
    logic [CTR_W-1:0] center;
  } piece_t;

  // Mask with every cell of one column set.
  function automatic board_t colMask(input int unsigned col);
    board_t m;
    m = '0;
    for (int unsigned r = 0; r < BOARD_H; r++) m[r*BOARD_W + col] = 1'b1;
    return m;
  endfunction

  localparam board_t COL0  = colMask(0);
  localparam board_t COL11 = colMask(BOARD_W - 1);
  localparam board_t ROW11 = board_t'({BOARD_W{1'b1}}) << (CELLS - BOARD_W);

endpackage

// File: rtl/piece_ctrl_if.sv
// Spawn and rotator handshake bundle between the controller and its environment.
interface piece_ctrl_if;
  import piece_ctrl_pkg::*;

  board_t           spawn_sqs;
  logic [CTR_W-1:0] spawn_center;
  logic             spawn_valid;
  logic             spawn_req;

  board_t           rot_new_sqs;
  logic             rot_can_rotate;
  logic [CTR_W-1:0] rot_center;
  board_t           rot_cur_sqs;
  board_t           rot_background;

  modport master (
    output spawn_req, rot_center, rot_cur_sqs, rot_background,
    input  spawn_sqs, spawn_center, spawn_valid, rot_new_sqs, rot_can_rotate
  );

  modport slave (
    input  spawn_req, rot_center, rot_cur_sqs, rot_background,
    output spawn_sqs, spawn_center, spawn_valid, rot_new_sqs, rot_can_rotate
  );
endinterface

// File: rtl/piece_shift_chk.sv
// Combinational legality check and shifted masks for left/right/down moves.
module piece_shift_chk
  import piece_ctrl_pkg::*;
(
  input  board_t curSqs,
  input  board_t background,
  output logic   leftOk_c,
  output logic   rightOk_c,
  output logic   downOk_c,
  output board_t leftSqs_c,
  output board_t rightSqs_c,
  output board_t downSqs_c
);

  // A move is legal when the piece is off the edge it moves toward and the shifted mask hits no locked cell.
  always_comb begin
    leftSqs_c  = curSqs >> 1;
    rightSqs_c = curSqs << 1;
    downSqs_c  = curSqs << BOARD_W;
    leftOk_c   = ((curSqs & COL0)  == '0) && ((leftSqs_c  & background) == '0);
    rightOk_c  = ((curSqs & COL11) == '0) && ((rightSqs_c & background) == '0);
    downOk_c   = ((curSqs & ROW11) == '0) && ((downSqs_c  & background) == '0);
  end

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece controller: spawn, move, rotate via external rotator, lock and row clearing.
module piece_ctrl
  import piece_ctrl_pkg::*;
#(
  parameter int unsigned ROT_LAT = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               btn_rot,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_down,
  input  logic               tick,
  piece_ctrl_if.master       bus,
  output board_t             background,
  output board_t             cur_sqs,
  output logic [LINES_W-1:0] lines,
  output logic               game_over
);

  localparam int unsigned CNT_W = (ROT_LAT > 1) ? $clog2(ROT_LAT) : 1;

  state_t           state, stateD;
  logic [CTR_W-1:0] center, centerD;
  logic [ROW_W-1:0] rowPtr, rowD;
  logic [CNT_W-1:0] rotCnt, cntD;
  logic [LINES_W-1:0] linesD;
  board_t           curD, bgD, keepMask;
  logic             spawnReq, rowFull;
  piece_t           spawnPiece;

  logic   leftOk, rightOk, downOk;
  board_t leftSqs, rightSqs, downSqs;

  piece_shift_chk u_shift (
    .curSqs     (cur_sqs),
    .background (background),
    .leftOk_c   (leftOk),
    .rightOk_c  (rightOk),
    .downOk_c   (downOk),
    .leftSqs_c  (leftSqs),
    .rightSqs_c (rightSqs),
    .downSqs_c  (downSqs)
  );

  assign spawnPiece = '{sqs: bus.spawn_sqs, center: bus.spawn_center};

  // Rows at and above the pointer take the row above them; rows below are kept.
  assign keepMask = {CELLS{1'b1}} << (BOARD_W * (32'(rowPtr) + 32'd1));
  assign rowFull  = (background[BOARD_W*32'(rowPtr) +: BOARD_W] == {BOARD_W{1'b1}});

  assign bus.spawn_req      = spawnReq;
  assign bus.rot_center     = center;
  assign bus.rot_cur_sqs    = cur_sqs;
  assign bus.rot_background = background;

  // Next-state and datapath update selection.
  always_comb begin
    stateD  = state;
    curD    = cur_sqs;
    centerD = center;
    bgD     = background;
    linesD  = lines;
    rowD    = rowPtr;
    cntD    = rotCnt;
    case (state)
      ST_IDLE: if (start) stateD = ST_SPAWN;
      ST_SPAWN: begin
        if (bus.spawn_valid) begin
          if ((spawnPiece.sqs & background) != '0) begin
            stateD = ST_OVER;
          end else begin
            curD    = spawnPiece.sqs;
            centerD = spawnPiece.center;
            stateD  = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (btn_rot) begin
          cntD   = '0;
          stateD = ST_ROT_WAIT;
        end else if (btn_left) begin
          if (leftOk) begin
            curD    = leftSqs;
            centerD = center - CTR_W'(1);
          end
        end else if (btn_right) begin
          if (rightOk) begin
            curD    = rightSqs;
            centerD = center + CTR_W'(1);
          end
        end else if (btn_down || tick) begin
          if (downOk) begin
            curD    = downSqs;
            centerD = center + CTR_W'(BOARD_W);
          end else begin
            stateD = ST_LOCK;
          end
        end
      end
      ST_ROT_WAIT: begin
        if (rotCnt == CNT_W'(ROT_LAT - 1)) stateD = ST_ROT_SAMPLE;
        else cntD = rotCnt + CNT_W'(1);
      end
      ST_ROT_SAMPLE: begin
        if (bus.rot_can_rotate) curD = bus.rot_new_sqs;
        stateD = ST_READY;
      end
      ST_LOCK: begin
        bgD    = background | cur_sqs;
        curD   = '0;
        rowD   = ROW_W'(BOARD_H - 1);
        stateD = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (rowFull) begin
          bgD = (background & keepMask) | ((background << BOARD_W) & ~keepMask);
          if (lines != {LINES_W{1'b1}}) linesD = lines + LINES_W'(1);
        end else if (rowPtr == '0) begin
          stateD = ST_SPAWN;
        end else begin
          rowD = rowPtr - ROW_W'(1);
        end
      end
      ST_OVER: stateD = ST_OVER;
      default: stateD = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cur_sqs    <= '0;
      background <= '0;
      center     <= '0;
      lines      <= '0;
      rowPtr     <= '0;
      rotCnt     <= '0;
      spawnReq   <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= stateD;
      cur_sqs    <= curD;
      background <= bgD;
      center     <= centerD;
      lines      <= linesD;
      rowPtr     <= rowD;
      rotCnt     <= cntD;
      spawnReq   <= (stateD == ST_SPAWN);
      game_over  <= (stateD == ST_OVER);
    end
  end

endmodule

// File: doc/piece_ctrl.md
PIECE_CTRL -- requirements
Module: piece_ctrl

Interface
REQ-001 Parameter: ROT_LAT, 1, cycles from driving rotator inputs to valid rotator outputs.
REQ-002 Parameter: GAME_CYC, none, board fixed at 12x12; cell index i, row i/12 (0 = top), column i%12.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 start  in  1  pulse; leaves IDLE and requests the first piece.
REQ-006 spawn_sqs  in  144  new-piece cell mask, valid while spawn_valid=1.
REQ-007 spawn_center  in  10  new-piece rotation centre index (0-143), valid with spawn_sqs.
REQ-008 spawn_valid  in  1  spawn_sqs/spawn_center valid; consumed in SPAWN.
REQ-009 btn_rot, btn_left, btn_right, btn_down  in  1 each  single-cycle move request pulses.
REQ-010 tick  in  1  gravity pulse; same effect as btn_down.
REQ-011 rot_new_sqs  in  144  rotator result mask.
REQ-012 rot_can_rotate  in  1  rotator legality flag.
REQ-013 rot_center  out  10  centre driven to rotator.
REQ-014 rot_cur_sqs  out  144  piece mask driven to rotator.
REQ-015 background  out  144  locked cells; also driven to rotator backGround.
REQ-016 cur_sqs  out  144  active piece mask.
REQ-017 spawn_req  out  1  high in SPAWN while waiting for spawn_valid.
REQ-018 lines  out  8  cleared-row count, saturating at 255.
REQ-019 game_over  out  1  high in OVER state.

Function
REQ-020 States: IDLE, SPAWN, READY, ROT_WAIT, ROT_SAMPLE, LOCK, CLEAR, OVER.
REQ-021 IDLE -> SPAWN on start; other inputs ignored.
REQ-022 SPAWN: spawn_req=1; on spawn_valid, if spawn_sqs & background nonzero -> OVER, else load cur_sqs/centre -> READY.
REQ-023 READY accepts one request per cycle, priority rot > left > right > down/tick; requests arriving outside READY are dropped.
REQ-024 Left: legal if no set cell in column 0 and (cur_sqs>>1)&background==0; then cur_sqs>>=1, centre-=1, same cycle; illegal -> no change.
REQ-025 Right: legal if no set cell in column 11 and (cur_sqs<<1)&background==0; then cur_sqs<<=1, centre+=1.
REQ-026 Down: legal if no set cell in row 11 and (cur_sqs<<12)&background==0; then cur_sqs<<=12, centre+=12; illegal -> LOCK.
REQ-027 Rotate: READY -> ROT_WAIT holding rot_cur_sqs/rot_center stable for ROT_LAT cycles, then ROT_SAMPLE.
REQ-028 ROT_SAMPLE: if rot_can_rotate=1, cur_sqs<=rot_new_sqs, centre unchanged; else no change; -> READY.
REQ-029 rot_cur_sqs=cur_sqs and rot_center=centre at all times.
REQ-030 LOCK: background<=background|cur_sqs, cur_sqs<=0, row pointer<=11 -> CLEAR (one cycle).
REQ-031 CLEAR: one row per cycle from 11 to 0; full row: rows above shift down one, row 0 zeroed, pointer unchanged, lines+=1; else pointer-=1; after row 0 checked -> SPAWN.
REQ-032 Max CLEAR duration 16 cycles (12 rows + 4 removals); all-zero row 0 after a shift terminates scan.
REQ-033 OVER: game_over=1, holds until reset; start ignored.
REQ-034 Centre arithmetic 10-bit unsigned; never leaves 0-143 given REQ-024..026 legality.

Reset
REQ-035 resetn=0 at posedge: state IDLE, cur_sqs=0, background=0, centre=0, lines=0, spawn_req=0, game_over=0.
REQ-036 Reset mid-rotation or mid-CLEAR abandons the operation; no partial background update survives.

Structure
REQ-037 Shared package holds state encoding, BOARD_W=12, BOARD_H=12, CELLS=144, row/column mask constants (COL0, COL11, ROW11).
REQ-038 One sub-module natural: piece_shift_chk (combinational left/right/down legality and shifted masks); rotator instantiated outside.

Verification
REQ-039 Spawn centre 5, cells {4,5,6}, btn_left x5 -> after 4 moves cells {0,1,2}, centre 1; 5th ignored.
REQ-040 Same piece, btn_rot with stub rot_can_rotate=0 -> cur_sqs unchanged after ROT_SAMPLE; =1 -> cur_sqs=rot_new_sqs 2 cycles after request.
REQ-041 btn_rot and btn_left same cycle -> only rotate performed, left dropped.
REQ-042 Row 11 cells 0-8 locked, piece {141,142,143} dropped by ticks -> row cleared, lines=1, background row 11 = 0, SPAWN entered.
REQ-043 spawn_sqs overlapping background -> OVER, game_over=1, stays until resetn=0.
REQ-044 resetn=0 during CLEAR -> next cycle all outputs at REQ-035 values.
